// File: rtl/icon_overlay.sv
// icon_overlay: overlays NUM_ICONS independently placed, shape-selectable icons
// onto the VGA pixel stream. Placement updates are staged in shadow registers
// and committed at frame_start so a frame is never drawn with half-applied updates.
// Rowpx/Colpx to icon/icon_id/collision latency is fixed at 3 cycles.
// Optional feature macro: ICON_SCALE2X_EN (each icon drawn at twice its ROM size).
module icon_overlay #(
    parameter int NUM_ICONS  = 2,
    parameter int ICON_SIZE  = 16,
    parameter int LOC_SHIFT  = 2,
    parameter int SHAPE_BITS = 3,
    parameter int PIX_BITS   = 2,
    parameter int COORD_W    = 10,
    localparam int IDW = (NUM_ICONS > 1) ? $clog2(NUM_ICONS) : 1,
    localparam int SW  = $clog2(ICON_SIZE),
    localparam int AW  = SHAPE_BITS + 2 * SW
) (
    input  logic                          vga_clock,
    input  logic                          reset_n,
    input  logic                          frame_start,
    input  logic                          upd_valid,
    output logic                          upd_ready,
    input  logic [IDW-1:0]                upd_sel,
    input  logic                          upd_en,
    input  logic [7:0]                    upd_locx,
    input  logic [7:0]                    upd_locy,
    input  logic [SHAPE_BITS-1:0]         upd_info,
    input  logic [COORD_W-1:0]            Rowpx,
    input  logic [COORD_W-1:0]            Colpx,
    output logic [NUM_ICONS*AW-1:0]       rom_addr,
    input  logic [NUM_ICONS*PIX_BITS-1:0] rom_data,
    output logic [PIX_BITS-1:0]           icon,
    output logic [IDW-1:0]                icon_id,
    output logic                          collision
);

    // Relative coordinates carry two spare bits over the widest operand so an
    // icon near a screen edge clips instead of wrapping to the opposite edge.
    localparam int LPW = 8 + LOC_SHIFT;
    localparam int RW  = ((COORD_W > LPW) ? COORD_W : LPW) + 2;

`ifdef ICON_SCALE2X_EN
    localparam int FOOT = 2 * ICON_SIZE;
    localparam int OFFS = ICON_SIZE;
    localparam int RSH  = 1;
`else
    localparam int FOOT = ICON_SIZE;
    localparam int OFFS = ICON_SIZE / 2;
    localparam int RSH  = 0;
`endif

    logic                  rdy_q;
    logic                  accept;
    logic [NUM_ICONS-1:0]  pend_q;
    logic [NUM_ICONS-1:0]  sh_en_q;
    logic [NUM_ICONS-1:0]  act_en_q;
    logic [7:0]            sh_locx_q  [NUM_ICONS];
    logic [7:0]            sh_locy_q  [NUM_ICONS];
    logic [SHAPE_BITS-1:0] sh_info_q  [NUM_ICONS];
    logic [7:0]            act_locx_q [NUM_ICONS];
    logic [7:0]            act_locy_q [NUM_ICONS];
    logic [SHAPE_BITS-1:0] act_info_q [NUM_ICONS];

    logic [RW-1:0]               rel_r;
    logic [RW-1:0]               rel_c;
    logic [NUM_ICONS-1:0]        inside_d;
    logic [NUM_ICONS-1:0]        inside1_q;
    logic [NUM_ICONS-1:0]        inside2_q;
    logic [NUM_ICONS*AW-1:0]     rom_addr_d;
    logic [NUM_ICONS*AW-1:0]     rom_addr_q;

    logic [PIX_BITS-1:0]         pix;
    logic                        hit;
    logic                        multi;
    logic [PIX_BITS-1:0]         icon_d;
    logic [PIX_BITS-1:0]         icon_q;
    logic [IDW-1:0]              icon_id_d;
    logic [IDW-1:0]              icon_id_q;
    logic                        coll_d;
    logic                        coll_q;

    assign upd_ready = rdy_q & ~frame_start;
    assign accept    = upd_valid & upd_ready;
    assign rom_addr  = rom_addr_q;
    assign icon      = icon_q;
    assign icon_id   = icon_id_q;
    assign collision = coll_q;

    // Shadow capture on accepted updates; commit pending shadows to active at frame_start.
    always_ff @(posedge vga_clock or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q    <= 1'b0;
            pend_q   <= '0;
            sh_en_q  <= '0;
            act_en_q <= '0;
            for (int unsigned i = 0; i < NUM_ICONS; i++) begin
                sh_locx_q[i]  <= '0;
                sh_locy_q[i]  <= '0;
                sh_info_q[i]  <= '0;
                act_locx_q[i] <= '0;
                act_locy_q[i] <= '0;
                act_info_q[i] <= '0;
            end
        end else begin
            rdy_q <= 1'b1;
            if (frame_start) begin
                for (int unsigned i = 0; i < NUM_ICONS; i++) begin
                    if (pend_q[i]) begin
                        act_en_q[i]   <= sh_en_q[i];
                        act_locx_q[i] <= sh_locx_q[i];
                        act_locy_q[i] <= sh_locy_q[i];
                        act_info_q[i] <= sh_info_q[i];
                    end
                end
                pend_q <= '0;
            end else begin
                // Out-of-range selects match no channel and are silently dropped.
                for (int unsigned i = 0; i < NUM_ICONS; i++) begin
                    if (accept && (upd_sel == IDW'(i))) begin
                        sh_en_q[i]   <= upd_en;
                        sh_locx_q[i] <= upd_locx;
                        sh_locy_q[i] <= upd_locy;
                        sh_info_q[i] <= upd_info;
                        pend_q[i]    <= 1'b1;
                    end
                end
            end
        end
    end

    // Stage 1 combinational: per-channel relative position, footprint test and ROM address.
    always_comb begin
        inside_d   = '0;
        rom_addr_d = '0;
        rel_r      = '0;
        rel_c      = '0;
        for (int unsigned i = 0; i < NUM_ICONS; i++) begin
            rel_r = RW'(Rowpx) - (RW'(act_locy_q[i]) << LOC_SHIFT) + RW'(OFFS);
            rel_c = RW'(Colpx) - (RW'(act_locx_q[i]) << LOC_SHIFT) + RW'(OFFS);
            inside_d[i] = act_en_q[i]
                        && !rel_r[RW-1] && (rel_r < RW'(FOOT))
                        && !rel_c[RW-1] && (rel_c < RW'(FOOT));
            rom_addr_d[i*AW +: AW] = {act_info_q[i], rel_r[RSH +: SW], rel_c[RSH +: SW]};
        end
    end

    // Stages 1 and 2 registers: ROM address issue, footprint flag delayed to meet ROM data.
    always_ff @(posedge vga_clock or negedge reset_n) begin
        if (!reset_n) begin
            inside1_q  <= '0;
            inside2_q  <= '0;
            rom_addr_q <= '0;
        end else begin
            inside1_q  <= inside_d;
            inside2_q  <= inside1_q;
            rom_addr_q <= rom_addr_d;
        end
    end

    // Stage 3 combinational: priority select of the lowest opaque channel, overlap detect.
    always_comb begin
        icon_d    = '0;
        icon_id_d = '0;
        hit       = 1'b0;
        multi     = 1'b0;
        pix       = '0;
        for (int unsigned i = 0; i < NUM_ICONS; i++) begin
            pix = rom_data[i*PIX_BITS +: PIX_BITS];
            if (inside2_q[i] && (pix != '0)) begin
                if (hit) begin
                    multi = 1'b1;
                end else begin
                    icon_d    = pix;
                    icon_id_d = IDW'(i);
                    hit       = 1'b1;
                end
            end
        end
        coll_d = frame_start ? 1'b0 : (coll_q | multi);
    end

    // Stage 3 registers: rendered pixel, winning channel and sticky collision flag.
    always_ff @(posedge vga_clock or negedge reset_n) begin
        if (!reset_n) begin
            icon_q    <= '0;
            icon_id_q <= '0;
            coll_q    <= 1'b0;
        end else begin
            icon_q    <= icon_d;
            icon_id_q <= icon_id_d;
            coll_q    <= coll_d;
        end
    end

endmodule

// File: tb/tb_icon_overlay.sv
// tb_icon_overlay: self-checking bench for icon_overlay with a bench-side ROM
// and a behavioural model that renders pixels from integer geometry.
module tb_icon_overlay;

    localparam int NI  = 2;
    localparam int ISZ = 16;
    localparam int SB  = 3;
    localparam int PB  = 2;
    localparam int CW  = 10;
    localparam int IDW = 1;
    localparam int AW  = SB + 2 * 4;

`ifdef ICON_SCALE2X_EN
    localparam int SCL = 2;
`else
    localparam int SCL = 1;
`endif
    localparam int FOOT = ISZ * SCL;
    localparam int OFF  = FOOT / 2;

    logic              clk;
    logic              reset_n;
    logic              frame_start;
    logic              upd_valid;
    logic              upd_ready;
    logic [IDW-1:0]    upd_sel;
    logic              upd_en;
    logic [7:0]        upd_locx;
    logic [7:0]        upd_locy;
    logic [SB-1:0]     upd_info;
    logic [CW-1:0]     Rowpx;
    logic [CW-1:0]     Colpx;
    logic [NI*AW-1:0]  rom_addr;
    logic [NI*PB-1:0]  rom_data;
    logic [PB-1:0]     icon;
    logic [IDW-1:0]    icon_id;
    logic              collision;

    icon_overlay #(
        .NUM_ICONS (NI),
        .ICON_SIZE (ISZ),
        .LOC_SHIFT (2),
        .SHAPE_BITS(SB),
        .PIX_BITS  (PB),
        .COORD_W   (CW)
    ) dut (
        .vga_clock  (clk),
        .reset_n    (reset_n),
        .frame_start(frame_start),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_sel    (upd_sel),
        .upd_en     (upd_en),
        .upd_locx   (upd_locx),
        .upd_locy   (upd_locy),
        .upd_info   (upd_info),
        .Rowpx      (Rowpx),
        .Colpx      (Colpx),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .icon       (icon),
        .icon_id    (icon_id),
        .collision  (collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Icon ROMs, one per channel, synchronous 1-cycle read.
    logic [PB-1:0] rom_mem [NI][1 << AW];
    always_ff @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            rom_data[i*PB +: PB] <= rom_mem[i][rom_addr[i*AW +: AW]];
        end
    end

    function automatic logic [PB-1:0] pat(input int ch, input int a);
        return PB'((a + ch) % 4);
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: channel state and in-flight expected pixels.
    bit  m_pend   [NI];
    bit  m_sh_en  [NI];
    int  m_sh_x   [NI];
    int  m_sh_y   [NI];
    int  m_sh_inf [NI];
    bit  m_act_en [NI];
    int  m_act_x  [NI];
    int  m_act_y  [NI];
    int  m_act_inf[NI];
    bit  m_coll;

    typedef struct {
        logic [PB-1:0]  ic;
        logic [IDW-1:0] id;
        bit             multi;
    } exp_t;
    exp_t q[$];

    function automatic void model_pix(input int r, input int c, output logic [PB-1:0] ic,
                                      output logic [IDW-1:0] id, output bit multi);
        int n, dr, dc, a;
        logic [PB-1:0] d;
        n  = 0;
        ic = '0;
        id = '0;
        for (int ch = 0; ch < NI; ch++) begin
            if (m_act_en[ch]) begin
                dr = r - m_act_y[ch] * 4 + OFF;
                dc = c - m_act_x[ch] * 4 + OFF;
                if (dr >= 0 && dr < FOOT && dc >= 0 && dc < FOOT) begin
                    a = m_act_inf[ch] * ISZ * ISZ + (dr / SCL) * ISZ + (dc / SCL);
                    d = rom_mem[ch][a];
                    if (d != 0) begin
                        n++;
                        if (n == 1) begin
                            ic = d;
                            id = IDW'(ch);
                        end
                    end
                end
            end
        end
        multi = (n >= 2);
    endfunction

    function automatic void model_clear();
        for (int ch = 0; ch < NI; ch++) begin
            m_pend[ch] = 0;   m_sh_en[ch] = 0;  m_sh_x[ch] = 0;  m_sh_y[ch] = 0;
            m_sh_inf[ch] = 0; m_act_en[ch] = 0; m_act_x[ch] = 0; m_act_y[ch] = 0;
            m_act_inf[ch] = 0;
        end
        m_coll = 0;
        q.delete();
    endfunction

    // One pixel clock: check the pixel issued three cycles ago, then drive new inputs.
    task automatic step(input bit fs, input bit v, input int sel, input bit en,
                        input int lx, input int ly, input int inf, input int r, input int c);
        exp_t e;
        r = r & ((1 << CW) - 1);
        c = c & ((1 << CW) - 1);
        @(negedge clk);
        if (q.size() == 3) begin
            e = q.pop_front();
            m_coll = frame_start ? 1'b0 : (m_coll | e.multi);
            chk("icon", 32'(icon), 32'(e.ic));
            chk("icon_id", 32'(icon_id), 32'(e.id));
            chk("collision", 32'(collision), 32'(m_coll));
        end
        frame_start = fs;
        upd_valid   = v;
        upd_sel     = IDW'(sel);
        upd_en      = en;
        upd_locx    = 8'(lx);
        upd_locy    = 8'(ly);
        upd_info    = SB'(inf);
        Rowpx       = CW'(r);
        Colpx       = CW'(c);
        model_pix(r, c, e.ic, e.id, e.multi);
        q.push_back(e);
        if (fs) begin
            for (int ch = 0; ch < NI; ch++) begin
                if (m_pend[ch]) begin
                    m_act_en[ch]  = m_sh_en[ch];
                    m_act_x[ch]   = m_sh_x[ch];
                    m_act_y[ch]   = m_sh_y[ch];
                    m_act_inf[ch] = m_sh_inf[ch];
                end
                m_pend[ch] = 0;
            end
        end else if (v && sel < NI) begin
            m_sh_en[ch_idx(sel)]  = en;
            m_sh_x[ch_idx(sel)]   = lx;
            m_sh_y[ch_idx(sel)]   = ly;
            m_sh_inf[ch_idx(sel)] = inf;
            m_pend[ch_idx(sel)]   = 1;
        end
        #1;
        chk("upd_ready", 32'(upd_ready), 32'(!fs));
    endtask

    function automatic int ch_idx(input int s);
        return s;
    endfunction

    task automatic hold(input int r, input int c, input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, r, c);
    endtask

    task automatic upd(input int sel, input bit en, input int lx, input int ly, input int inf);
        step(0, 1, sel, en, lx, ly, inf, 0, 0);
    endtask

    task automatic fstart();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_icon", 32'(icon), 0);
        chk("rst_icon_id", 32'(icon_id), 0);
        chk("rst_collision", 32'(collision), 0);
        chk("rst_upd_ready", 32'(upd_ready), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        frame_start = 1'b0;
        upd_valid   = 1'b0;
        repeat (2) @(negedge clk);
        model_clear();
        reset_n = 1'b1;
    endtask

    typedef struct {
        int r;
        int c;
        bit ins;
        int ri;
        int ci;
    } vec_t;
    vec_t tbl[8];

    initial begin
        bit fs, v, en;
        int sel, lx, ly, inf, r, c;
        logic [PB-1:0] ev;

        // Placement of ch0 at loc (20,10), info 3: hand-derived footprint samples.
`ifdef ICON_SCALE2X_EN
        tbl[0] = '{24, 64, 1, 0, 0};
        tbl[1] = '{24, 63, 0, 0, 0};
        tbl[2] = '{24, 96, 0, 0, 0};
        tbl[3] = '{55, 95, 1, 15, 15};
        tbl[4] = '{40, 80, 1, 8, 8};
        tbl[5] = '{23, 80, 0, 0, 0};
        tbl[6] = '{41, 81, 1, 8, 8};
        tbl[7] = '{56, 80, 0, 0, 0};
`else
        tbl[0] = '{32, 72, 1, 0, 0};
        tbl[1] = '{32, 71, 0, 0, 0};
        tbl[2] = '{32, 88, 0, 0, 0};
        tbl[3] = '{32, 87, 1, 0, 15};
        tbl[4] = '{47, 80, 1, 15, 8};
        tbl[5] = '{48, 80, 0, 0, 0};
        tbl[6] = '{31, 80, 0, 0, 0};
        tbl[7] = '{40, 80, 1, 8, 8};
`endif
        for (int ch = 0; ch < NI; ch++)
            for (int a = 0; a < (1 << AW); a++) rom_mem[ch][a] = pat(ch, a);

        reset_n = 1'b1; frame_start = 0; upd_valid = 0; upd_sel = '0; upd_en = 0;
        upd_locx = '0; upd_locy = '0; upd_info = '0; Rowpx = '0; Colpx = '0;
        model_clear();
        repeat (2) @(negedge clk);
        do_reset();
        hold(0, 0, 5);

        // Single channel placement and footprint edges.
        upd(0, 1, 20, 10, 3);
        fstart();
        for (int i = 0; i < 8; i++) begin
            hold(tbl[i].r, tbl[i].c, 4);
            ev = tbl[i].ins ? pat(0, 3 * 256 + tbl[i].ri * 16 + tbl[i].ci) : '0;
            chk("tbl_icon", 32'(icon), 32'(ev));
            if (tbl[i].ins)
                chk("tbl_rom_addr", 32'(rom_addr[AW-1:0]),
                    32'(3 * 256 + tbl[i].ri * 16 + tbl[i].ci));
        end

`ifndef ICON_SCALE2X_EN
        // Update staged until frame_start; last write before commit wins.
        upd(1, 1, 30, 30, 1);
        hold(120, 120, 4);
        chk("stage_icon", 32'(icon), 0);
        fstart();
        hold(120, 120, 4);
        chk("commit_icon", 32'(icon), 1);
        chk("commit_id", 32'(icon_id), 1);
        upd(1, 1, 5, 5, 1);
        upd(1, 1, 6, 6, 1);
        fstart();
        hold(28, 28, 4);
        chk("lastwin_icon", 32'(icon), 1);
        hold(13, 13, 4);
        chk("lastwin_old", 32'(icon), 0);

        // Overlap priority and sticky collision.
        upd(0, 1, 40, 40, 2);
        upd(1, 1, 40, 40, 2);
        fstart();
        hold(160, 161, 4);
        chk("ovl_icon", 32'(icon), 1);
        chk("ovl_id", 32'(icon_id), 0);
        chk("ovl_coll", 32'(collision), 1);
        hold(160, 160, 4);
        chk("see_through_icon", 32'(icon), 1);
        chk("see_through_id", 32'(icon_id), 1);
        chk("coll_sticky", 32'(collision), 1);
        fstart();
        hold(0, 0, 4);
        chk("coll_cleared", 32'(collision), 0);

        // Screen-edge clipping.
        upd(0, 1, 0, 0, 0);
        fstart();
        hold(1, 1, 4);
        chk("clip_in", 32'(icon), 1);
        hold(0, 1016, 4);
        chk("clip_col", 32'(icon), 0);
        hold(1016, 1, 4);
        chk("clip_row", 32'(icon), 0);
`endif
        for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 1000; cc < 1040; cc++) step(0, 0, 0, 0, 0, 0, 0, rr * 6, cc);
            for (int cc = 1000; cc < 1040; cc++) step(0, 0, 0, 0, 0, 0, 0, cc, rr * 6);
        end

        // upd_valid held across frame_start.
        step(0, 1, 0, 1, 50, 50, 1, 0, 0);
        step(1, 1, 0, 1, 60, 60, 1, 0, 0);
        step(0, 1, 0, 1, 70, 70, 1, 0, 0);
`ifndef ICON_SCALE2X_EN
        hold(201, 201, 4);
        chk("held_first", 32'(icon), 1);
        fstart();
        hold(281, 281, 4);
        chk("held_third", 32'(icon), 1);
        hold(241, 241, 4);
        chk("held_skipped", 32'(icon), 0);
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            fs  = ($urandom_range(0, 47) == 0);
            v   = ($urandom_range(0, 5) == 0);
            sel = $urandom_range(0, 1);
            en  = ($urandom_range(0, 3) != 0);
            lx  = $urandom_range(0, 20);
            ly  = $urandom_range(0, 20);
            inf = $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0: begin r = $urandom_range(0, 1023); c = $urandom_range(0, 1023); end
                1: begin r = $urandom_range(0, 100);  c = $urandom_range(0, 100);  end
                default: begin
                    sel = $urandom_range(0, 1);
                    r = m_act_y[sel] * 4 + $urandom_range(0, 2 * FOOT) - FOOT;
                    c = m_act_x[sel] * 4 + $urandom_range(0, 2 * FOOT) - FOOT;
                end
            endcase
            step(fs, v, sel, en, lx, ly, inf, r, c);
        end

        // Reset mid-stream: pending and active state discarded.
        upd(0, 1, 10, 10, 1);
        do_reset();
        fstart();
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 0, 0, 0, 40 + k, 40);
        hold(40, 40, 4);
        chk("post_rst_icon", 32'(icon), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
